// File: rtl/eth_tx_arb.sv
// rtl/eth_tx_arb.sv - packet-granular two-port arbiter onto the 10G MAC TX stream
// Frames are never interleaved; a granted source that stalls mid-frame gets an abort beat and is drained.
module eth_tx_arb #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_STALL  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk156,
    input  logic                  eth_rst_n,
    input  logic                  s_axis_tx0_tvalid,
    output logic                  s_axis_tx0_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tx0_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tx0_tkeep,
    input  logic                  s_axis_tx0_tlast,
    input  logic                  s_axis_tx0_tuser,
    input  logic                  s_axis_tx1_tvalid,
    output logic                  s_axis_tx1_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tx1_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tx1_tkeep,
    input  logic                  s_axis_tx1_tlast,
    input  logic                  s_axis_tx1_tuser,
    output logic                  m_axis_tx_tvalid,
    input  logic                  m_axis_tx_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tx_tkeep,
    output logic                  m_axis_tx_tlast,
    output logic                  m_axis_tx_tuser,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1,
    output logic [7:0]            abort_cnt,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SEND, ABORT, DRAIN} state_t;

    state_t     state, state_nxt;
    logic       gnt, gnt_nxt;
    logic       last_served, last_served_nxt;
    logic       started, started_nxt;
    logic [7:0] stall_cnt, stall_cnt_nxt;
    logic       inc_pkt0, inc_pkt1, inc_abort;
    logic       sel_ready;

    logic                  sel_tvalid;
    logic [DATA_WIDTH-1:0] sel_tdata;
    logic [KEEP_WIDTH-1:0] sel_tkeep;
    logic                  sel_tlast;
    logic                  sel_tuser;

    assign sel_tvalid = gnt ? s_axis_tx1_tvalid : s_axis_tx0_tvalid;
    assign sel_tdata  = gnt ? s_axis_tx1_tdata  : s_axis_tx0_tdata;
    assign sel_tkeep  = gnt ? s_axis_tx1_tkeep  : s_axis_tx0_tkeep;
    assign sel_tlast  = gnt ? s_axis_tx1_tlast  : s_axis_tx0_tlast;
    assign sel_tuser  = gnt ? s_axis_tx1_tuser  : s_axis_tx0_tuser;

    assign s_axis_tx0_tready = sel_ready & ~gnt;
    assign s_axis_tx1_tready = sel_ready & gnt;
    assign busy              = (state != IDLE);

    always_comb begin
        state_nxt        = state;
        gnt_nxt          = gnt;
        last_served_nxt  = last_served;
        started_nxt      = started;
        stall_cnt_nxt    = stall_cnt;
        inc_pkt0         = 1'b0;
        inc_pkt1         = 1'b0;
        inc_abort        = 1'b0;
        sel_ready        = 1'b0;
        m_axis_tx_tvalid = 1'b0;
        m_axis_tx_tdata  = '0;
        m_axis_tx_tkeep  = '0;
        m_axis_tx_tlast  = 1'b0;
        m_axis_tx_tuser  = 1'b0;
        case (state)
            IDLE: begin
                if (s_axis_tx0_tvalid && s_axis_tx1_tvalid) begin
                    gnt_nxt = ~last_served;
                end else if (s_axis_tx1_tvalid) begin
                    gnt_nxt = 1'b1;
                end else begin
                    gnt_nxt = 1'b0;
                end
                if (s_axis_tx0_tvalid || s_axis_tx1_tvalid) begin
                    state_nxt     = SEND;
                    started_nxt   = 1'b0;
                    stall_cnt_nxt = '0;
                end
            end
            SEND: begin
                m_axis_tx_tvalid = sel_tvalid;
                m_axis_tx_tdata  = sel_tdata;
                m_axis_tx_tkeep  = sel_tkeep;
                m_axis_tx_tlast  = sel_tlast;
                m_axis_tx_tuser  = sel_tuser;
                sel_ready        = m_axis_tx_tready;
                if (sel_tvalid && m_axis_tx_tready) begin
                    started_nxt = 1'b1;
                end
                // An accepted tlast beat takes priority over the stall watchdog.
                if (sel_tvalid && m_axis_tx_tready && sel_tlast) begin
                    inc_pkt0        = ~gnt;
                    inc_pkt1        = gnt;
                    last_served_nxt = gnt;
                    state_nxt       = IDLE;
                end else if (sel_tvalid) begin
                    stall_cnt_nxt = '0;
                end else if (started) begin
                    if (stall_cnt == 8'(MAX_STALL - 1)) begin
                        state_nxt = ABORT;
                    end else begin
                        stall_cnt_nxt = stall_cnt + 8'd1;
                    end
                end
            end
            ABORT: begin
                m_axis_tx_tvalid = 1'b1;
                m_axis_tx_tkeep  = KEEP_WIDTH'(1);
                m_axis_tx_tlast  = 1'b1;
                m_axis_tx_tuser  = 1'b1;
                if (m_axis_tx_tready) begin
                    inc_abort = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                sel_ready = 1'b1;
                if (sel_tvalid && sel_tlast) begin
                    last_served_nxt = gnt;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (!eth_rst_n) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            last_served <= 1'b1;
            started     <= 1'b0;
            stall_cnt   <= '0;
            pkt_cnt0    <= '0;
            pkt_cnt1    <= '0;
            abort_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            last_served <= last_served_nxt;
            started     <= started_nxt;
            stall_cnt   <= stall_cnt_nxt;
            if (inc_pkt0) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_WIDTH'(1);
            end
            if (inc_pkt1) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_WIDTH'(1);
            end
            if (inc_abort && (abort_cnt != 8'hFF)) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// tb/tb_eth_tx_arb.sv - scoreboard bench for eth_tx_arb
`timescale 1ns/1ps
module tb_eth_tx_arb;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int MS = 4;
    localparam int CW = 16;

    logic clk156 = 1'b0;
    always #3.2 clk156 = ~clk156;

    logic          eth_rst_n;
    logic          s0_tvalid, s0_tready, s0_tlast, s0_tuser;
    logic [DW-1:0] s0_tdata;
    logic [KW-1:0] s0_tkeep;
    logic          s1_tvalid, s1_tready, s1_tlast, s1_tuser;
    logic [DW-1:0] s1_tdata;
    logic [KW-1:0] s1_tkeep;
    logic          m_tvalid, m_tready, m_tlast, m_tuser;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;
    logic [7:0]    abort_cnt;
    logic          busy;

    eth_tx_arb #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_STALL(MS), .CNT_WIDTH(CW)) dut (
        .clk156(clk156), .eth_rst_n(eth_rst_n),
        .s_axis_tx0_tvalid(s0_tvalid), .s_axis_tx0_tready(s0_tready), .s_axis_tx0_tdata(s0_tdata),
        .s_axis_tx0_tkeep(s0_tkeep), .s_axis_tx0_tlast(s0_tlast), .s_axis_tx0_tuser(s0_tuser),
        .s_axis_tx1_tvalid(s1_tvalid), .s_axis_tx1_tready(s1_tready), .s_axis_tx1_tdata(s1_tdata),
        .s_axis_tx1_tkeep(s1_tkeep), .s_axis_tx1_tlast(s1_tlast), .s_axis_tx1_tuser(s1_tuser),
        .m_axis_tx_tvalid(m_tvalid), .m_axis_tx_tready(m_tready), .m_axis_tx_tdata(m_tdata),
        .m_axis_tx_tkeep(m_tkeep), .m_axis_tx_tlast(m_tlast), .m_axis_tx_tuser(m_tuser),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .abort_cnt(abort_cnt), .busy(busy)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        int          gap;
    } beat_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        bit          is_abort;
    } exp_t;

    typedef struct {
        int port;
        int nbeats;
        int stall_after;
        int stall_len;
        bit tog;
        int exp_p0;
        int exp_p1;
        int exp_ab;
    } vec_t;

    beat_t src0_q[$];
    beat_t src1_q[$];
    exp_t  exp_q[$];
    int    gap0 = 0, gap1 = 0;
    int    errors = 0, checks = 0, cyc = 0, fid = 0, m_first = -1;
    bit    sb_en = 1'b1, tog = 1'b0, mirror_en = 1'b0, hold_pend = 1'b0, idle_pend = 1'b0;
    logic [63:0] hold_d;
    logic [9:0]  hold_c;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        s0_tvalid = (src0_q.size() > 0) && (gap0 == 0);
        s1_tvalid = (src1_q.size() > 0) && (gap1 == 0);
        if (src0_q.size() > 0) begin
            s0_tdata = src0_q[0].data; s0_tkeep = src0_q[0].keep;
            s0_tlast = src0_q[0].last; s0_tuser = src0_q[0].user;
        end else begin
            s0_tdata = '0; s0_tkeep = '0; s0_tlast = 1'b0; s0_tuser = 1'b0;
        end
        if (src1_q.size() > 0) begin
            s1_tdata = src1_q[0].data; s1_tkeep = src1_q[0].keep;
            s1_tlast = src1_q[0].last; s1_tuser = src1_q[0].user;
        end else begin
            s1_tdata = '0; s1_tkeep = '0; s1_tlast = 1'b0; s1_tuser = 1'b0;
        end
    endtask

    // Queue one frame at a source and push what the MAC should see for it.
    task automatic add_frame(input int port, input int nb, input int stall_after,
                             input int stall_len, input int first_gap, input bit ab);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < nb; i++) begin
            b.data = 64'hD000_0000_0000_0000 | (64'(port) << 48) | (64'(fid) << 16) | 64'(i);
            b.last = (i == nb - 1);
            b.keep = b.last ? 8'h0F : 8'hFF;
            b.user = b.last && ((fid % 2) == 1);
            b.gap  = (i == 0) ? first_gap : ((i == stall_after + 1) ? stall_len : 0);
            if (port == 0) begin
                if (src0_q.size() == 0) gap0 = b.gap;
                src0_q.push_back(b);
            end else begin
                if (src1_q.size() == 0) gap1 = b.gap;
                src1_q.push_back(b);
            end
            if (!ab || i <= stall_after) begin
                e.data = b.data; e.keep = b.keep; e.last = b.last; e.user = b.user; e.is_abort = 1'b0;
                exp_q.push_back(e);
            end
            if (ab && i == stall_after) begin
                e.data = '0; e.keep = 8'h01; e.last = 1'b1; e.user = 1'b1; e.is_abort = 1'b1;
                exp_q.push_back(e);
            end
        end
        fid++;
    endtask

    task automatic step();
        bit   f0, f1;
        exp_t e;
        @(negedge clk156);
        cyc++;
        if (hold_pend)
            check("hold_while_not_ready", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, {1'b1, hold_d, hold_c});
        hold_pend = m_tvalid && !m_tready;
        hold_d    = m_tdata;
        hold_c    = {m_tkeep, m_tlast, m_tuser};
        if (idle_pend) check("busy_after_tlast", busy, 1'b0);
        idle_pend = 1'b0;
        if (mirror_en && busy) check("tready1_mirror", {s0_tready, s1_tready}, {1'b0, m_tready});
        if (m_tvalid && m_first < 0) m_first = cyc;
        f0 = s0_tvalid && s0_tready;
        f1 = s1_tvalid && s1_tready;
        if (sb_en && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h with no beat expected", m_tdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_tdata, e.data);
                check("beat_ctrl", {m_tkeep, m_tlast, m_tuser}, {e.keep, e.last, e.user});
                if (e.last && !e.is_abort) idle_pend = 1'b1;
            end
        end
        @(posedge clk156);
        #1;
        if (f0) begin
            void'(src0_q.pop_front());
            gap0 = (src0_q.size() > 0) ? src0_q[0].gap : 0;
        end else if (gap0 > 0) gap0--;
        if (f1) begin
            void'(src1_q.pop_front());
            gap1 = (src1_q.size() > 0) ? src1_q[0].gap : 0;
        end else if (gap1 > 0) gap1--;
        m_tready = tog ? ~m_tready : 1'b1;
        drive_src();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((src0_q.size() > 0 || src1_q.size() > 0 || exp_q.size() > 0 || busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d beats still expected after %0d cycles", exp_q.size(), budget);
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   c0;
        bit   ab;
        vecs[0] = '{0, 3, -1, 0, 1'b0, 3, 2, 0};
        vecs[1] = '{1, 4, -1, 0, 1'b1, 3, 3, 0};
        vecs[2] = '{0, 5,  1, 3, 1'b0, 4, 3, 0};
        vecs[3] = '{0, 3,  0, 4, 1'b0, 4, 3, 1};
        vecs[4] = '{1, 1, -1, 0, 1'b1, 4, 4, 1};
        vecs[5] = '{0, 2,  0, 9, 1'b1, 4, 4, 2};
        vecs[6] = '{1, 3,  1, 5, 1'b1, 4, 4, 3};

        eth_rst_n = 1'b0;
        m_tready  = 1'b1;
        drive_src();
        repeat (2) @(posedge clk156);
        @(negedge clk156);
        check("rst_m_outputs", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser}, '0);
        check("rst_s_tready", {s0_tready, s1_tready}, 2'b00);
        check("rst_counters", {pkt_cnt0, pkt_cnt1, abort_cnt, busy}, '0);
        @(posedge clk156);
        #1;
        eth_rst_n = 1'b1;

        // Both ports loaded with back-to-back frames: expect p0,p1,p0,p1.
        add_frame(0, 2, -1, 0, 0, 1'b0);
        add_frame(1, 2, -1, 0, 0, 1'b0);
        add_frame(0, 2, -1, 0, 0, 1'b0);
        add_frame(1, 2, -1, 0, 0, 1'b0);
        drive_src();
        run_until_idle(200);
        check("alt_pkt_cnt", {pkt_cnt0, pkt_cnt1}, {16'd2, 16'd2});

        for (int i = 0; i < 7; i++) begin
            ab = (vecs[i].stall_len >= MS) && (vecs[i].stall_after >= 0) &&
                 (vecs[i].stall_after < vecs[i].nbeats - 1);
            m_tready  = 1'b1;
            tog       = vecs[i].tog;
            mirror_en = vecs[i].tog && (vecs[i].port == 1) && !ab;
            add_frame(vecs[i].port, vecs[i].nbeats, vecs[i].stall_after, vecs[i].stall_len, 0, ab);
            drive_src();
            c0 = cyc + 1;
            m_first = -1;
            run_until_idle(300);
            check($sformatf("vec%0d_bubble", i), m_first, c0 + 1);
            check($sformatf("vec%0d_counts", i), {pkt_cnt0, pkt_cnt1, abort_cnt},
                  {16'(vecs[i].exp_p0), 16'(vecs[i].exp_p1), 8'(vecs[i].exp_ab)});
            tog       = 1'b0;
            mirror_en = 1'b0;
            m_tready  = 1'b1;
        end

        // Port 0 aborts while port 1 becomes pending; port 1 is served next.
        add_frame(0, 3, 0, 4, 0, 1'b1);
        add_frame(1, 2, -1, 0, 2, 1'b0);
        drive_src();
        run_until_idle(300);
        check("abort_then_p1_counts", {pkt_cnt0, pkt_cnt1, abort_cnt}, {16'd4, 16'd5, 8'd4});

        // Reset pulse while beat 2 of a 5-beat frame is on the bus.
        sb_en = 1'b0;
        add_frame(0, 5, -1, 0, 0, 1'b0);
        exp_q.delete();
        drive_src();
        for (int i = 0; i < 20 && src0_q.size() != 4; i++) step();
        @(negedge clk156);
        check("rst_mid_beat2_present", {m_tvalid, m_tdata[15:0]}, {1'b1, 16'd1});
        eth_rst_n = 1'b0;
        @(posedge clk156);
        #1;
        eth_rst_n = 1'b1;
        src0_q.delete();
        gap0 = 0;
        hold_pend = 1'b0;
        idle_pend = 1'b0;
        drive_src();
        @(negedge clk156);
        check("rst_mid_idle", {m_tvalid, busy}, 2'b00);
        check("rst_mid_counters", {pkt_cnt0, pkt_cnt1, abort_cnt}, '0);
        @(posedge clk156);
        #1;
        sb_en = 1'b1;
        add_frame(0, 1, -1, 0, 0, 1'b0);
        add_frame(1, 1, -1, 0, 0, 1'b0);
        drive_src();
        run_until_idle(100);
        check("post_rst_tie_counts", {pkt_cnt0, pkt_cnt1}, {16'd1, 16'd1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
